// File: rtl/fft32_com_ctrl_pkg.sv
// Shared constants and FSM encoding for the 32-point radix-2 MDC commutator control.
package fft32_pkg;

    localparam int unsigned NSTG      = 5;
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned OUT_LAT   = 20;

    localparam int unsigned DLY_DEPTH [NSTG-1] = '{8, 4, 2, 1};

    // Stage k latency: delay-line depth of all earlier stages plus one butterfly register each.
    function automatic int unsigned stage_lat(input int unsigned k);
        int unsigned s;
        s = k;
        for (int unsigned i = 0; i < NSTG - 1; i++) begin
            if (i < k) s += DLY_DEPTH[i];
        end
        return s;
    endfunction

    localparam int unsigned LAT [NSTG] = '{stage_lat(0), stage_lat(1), stage_lat(2),
                                           stage_lat(3), stage_lat(4)};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN
    } state_t;

endpackage

// File: rtl/fft32_com_ctrl_if.sv
// Control/status bundle between the sample source and the commutator controller.
interface fft32_com_ctrl_if;

    logic       in_valid;
    logic [4:0] state_com_mode;
    logic [6:0] com_mask;
    logic [3:0] tw_idx;
    logic       out_valid;
    logic       frame_done;
    logic       busy;
    logic       err;

    modport master (
        output in_valid,
        input  state_com_mode, com_mask, tw_idx, out_valid, frame_done, busy, err
    );

    modport slave (
        input  in_valid,
        output state_com_mode, com_mask, tw_idx, out_valid, frame_done, busy, err
    );

endinterface

// File: rtl/fft32_com_ctrl_stage_tap.sv
// Per-stage valid delay line of depth LAT and the stage-local mod-16 sample counter.
module fft_stage_tap #(
    parameter int unsigned LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vin,
    output logic       vout,
    output logic [3:0] cnt
);

    if (LAT == 0) begin : g_direct
        assign vout = vin;
    end else begin : g_line
        logic [LAT-1:0] sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else begin
                sr[0] <= vin;
                for (int unsigned i = 1; i < LAT; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign vout = sr[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (vout) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/fft32_com_ctrl.sv
// Frame FSM, error/busy/frame_done tracking and registered commutator controls for the
// 32-point MDC pipeline; per-stage timing lives in fft_stage_tap.
module fft32_com_ctrl
    import fft32_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned NSTG  = 5
) (
    input logic             clk,
    input logic             rst_n,
    fft32_com_ctrl_if.slave bus
);

    // A mis-parameterised instance never accepts samples.
    localparam bit CFG_OK = (NSTG == fft32_pkg::NSTG) && (WIDTH > 0);
    localparam int unsigned FLT_W = $clog2(OUT_LAT + 1);

    state_t             state;
    logic               rdy;
    logic               acc;
    logic [3:0]         cnt0;
    logic [FLT_W-1:0]   inflight;
    logic               err_q;
    logic [NSTG-1:0]    vld;
    logic [3:0]         cnt [NSTG];
    logic [NSTG-1:0]    scm_q;
    logic [3:0]         cm_q;
    logic [3:0]         tw_q;
    logic [3:0]         idx4_q;
    logic               ov_q;
    logic               fd_q;

    // Reset release takes one edge to reach rdy, so the second edge is the first honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy <= 1'b0;
        else        rdy <= 1'b1;
    end

    assign acc = bus.in_valid & rdy & CFG_OK;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        fft_stage_tap #(.LAT(LAT[k])) u_tap (
            .clk  (clk),
            .rst_n(rst_n),
            .vin  (acc),
            .vout (vld[k]),
            .cnt  (cnt[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt0  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        state <= RUN;
                        cnt0  <= 4'd1;
                    end
                end
                RUN: begin
                    if (acc) begin
                        cnt0 <= cnt0 + 4'd1;
                        if (cnt0 == 4'(FRAME_LEN - 1)) state <= DRAIN;
                    end else begin
                        err_q <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (acc) begin
                        state <= RUN;
                        cnt0  <= 4'd1;
                    end else if (inflight == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A sample leaves the in-flight count on the edge that loads it into out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            scm_q    <= '0;
            cm_q     <= '0;
            tw_q     <= '0;
            idx4_q   <= '0;
            ov_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            case ({acc, scm_q[NSTG-1]})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            scm_q  <= vld;
            cm_q   <= {cnt[3][0], cnt[2][1], cnt[1][2], cnt[0][3]};
            tw_q   <= cnt[0];
            idx4_q <= cnt[NSTG-1];
            ov_q   <= scm_q[NSTG-1];
            fd_q   <= scm_q[NSTG-1] && (idx4_q == 4'(FRAME_LEN - 1));
        end
    end

    assign bus.state_com_mode = scm_q;
    assign bus.com_mask       = {3'b000, cm_q};
    assign bus.tw_idx         = tw_q;
    assign bus.out_valid      = ov_q;
    assign bus.frame_done     = fd_q;
    assign bus.err            = err_q;
    assign bus.busy           = (state != IDLE) | (|scm_q) | (inflight != '0) | ov_q;

endmodule

// File: tb/tb_fft32_com_ctrl.sv
// Directed and randomised checks of fft32_com_ctrl against a sample-history reference model.
module tb_fft32_com_ctrl;

    logic clk;
    logic rst_n;

    fft32_com_ctrl_if bus ();

    fft32_com_ctrl #(.WIDTH(9), .NSTG(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    int lats [5] = '{0, 9, 14, 17, 19};

    bit hist [$];
    int last_acc;
    bit err_m;
    int pos;
    int seg_start;
    int fd_cnt;
    int fd_rel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of accepted samples at edges before 'upto', modulo 16.
    function automatic int cnt_before(input int upto);
        int c;
        c = 0;
        for (int j = 0; j < upto && j < hist.size(); j++) c += int'(hist[j]);
        return c % 16;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_scm"},  32'(bus.state_com_mode), 32'd0);
        chk({tag, "_mask"}, 32'(bus.com_mask), 32'd0);
        chk({tag, "_tw"},   32'(bus.tw_idx), 32'd0);
        chk({tag, "_ov"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_fd"},   32'(bus.frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_err"},  32'(bus.err), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        hist.delete();
        last_acc = -1000;
        err_m = 1'b0;
        pos = 0;
        rst_n = 1'b1;
    endtask

    task automatic step(input bit v);
        int n;
        bit a;
        logic [4:0] e_scm;
        logic [6:0] e_mask;
        int c;
        bit e_ov;
        bit e_fd;
        bus.in_valid = v;
        @(posedge clk);
        #1;
        n = hist.size();
        a = v && (n >= 1);
        hist.push_back(a);
        if (a) begin
            last_acc = n;
            pos = (pos == 0) ? 1 : pos + 1;
            if (pos == 16) pos = 0;
        end else if (pos != 0) begin
            err_m = 1'b1;
            pos = 0;
        end
        e_scm = '0;
        e_mask = '0;
        for (int k = 0; k < 5; k++) begin
            if (n >= lats[k]) e_scm[k] = hist[n - lats[k]];
        end
        for (int k = 0; k < 4; k++) begin
            c = cnt_before(n - lats[k]);
            e_mask[k] = ((c >> (3 - k)) & 1) != 0;
        end
        e_ov = (n >= 20) ? hist[n - 20] : 1'b0;
        e_fd = e_ov && (cnt_before(n - 20) == 15);
        chk("scm",        32'(bus.state_com_mode), 32'(e_scm));
        chk("com_mask",   32'(bus.com_mask), 32'(e_mask));
        chk("tw_idx",     32'(bus.tw_idx), 32'(cnt_before(n)));
        chk("out_valid",  32'(bus.out_valid), 32'(e_ov));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("busy",       32'(bus.busy), 32'((n - last_acc) <= 20));
        chk("err",        32'(bus.err), 32'(err_m));
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_rel = n - seg_start;
        end
    endtask

    task automatic new_seg();
        seg_start = hist.size();
        fd_cnt = 0;
        fd_rel = -1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        do_reset();

        // Idle after reset: nothing moves.
        repeat (52) step(1'b0);

        // Single frame.
        new_seg();
        repeat (16) step(1'b1);
        repeat (25) step(1'b0);
        chk("single_fd_count", 32'(fd_cnt), 32'd1);
        chk("single_fd_cycle", 32'(fd_rel), 32'd35);

        // Two back-to-back frames.
        new_seg();
        repeat (32) step(1'b1);
        repeat (25) step(1'b0);
        chk("b2b_fd_count", 32'(fd_cnt), 32'd2);
        chk("b2b_fd_cycle", 32'(fd_rel), 32'd51);
        chk("b2b_err", 32'(bus.err), 32'd0);

        // Gap at sample 5.
        new_seg();
        repeat (5) step(1'b1);
        step(1'b0);
        repeat (4) step(1'b1);
        repeat (30) step(1'b0);
        chk("gap_fd_count", 32'(fd_cnt), 32'd0);
        chk("gap_err_sticky", 32'(bus.err), 32'd1);
        chk("gap_idle_busy", 32'(bus.busy), 32'd0);

        // Reset twelve samples into a frame, then a clean frame.
        do_reset();
        repeat (2) step(1'b0);
        new_seg();
        repeat (12) step(1'b1);
        do_reset();
        new_seg();
        repeat (32) step(1'b0);
        chk("rst_no_fd", 32'(fd_cnt), 32'd0);
        new_seg();
        repeat (16) step(1'b1);
        repeat (25) step(1'b0);
        chk("post_rst_fd_count", 32'(fd_cnt), 32'd1);
        chk("post_rst_fd_cycle", 32'(fd_rel), 32'd35);

        // Random bursts and gaps, including frames longer and shorter than 16.
        for (int b = 0; b < 12; b++) begin
            int len;
            int gap;
            len = int'($urandom_range(1, 36));
            gap = int'($urandom_range(0, 3));
            repeat (len) step(1'b1);
            repeat (gap) step(1'b0);
        end
        repeat (25) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
